switch_allocator: RTL and testbench

//  Per-router switch allocator that grants Buffer_Unit packet requests to router output ports.
//  - Routes each input's registered dest with XY dimension-order routing.
//  - Arbitrates round-robin per output and locks the output to the winning input for the

---
 rtl/noc_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/switch_allocator.sv | 109 ++++++++++
 tb/tb_switch_allocator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, allocator state encoding and XY routing.
package noc_pkg;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   typedef enum logic {FREE = 1'b0, BUSY = 1'b1} alloc_state_t;

   // Dimension-order routing: resolve x first, then y; equal coordinates eject locally.
   function automatic logic [2:0] xy_route(input logic [3:0] d,
                                           input logic [1:0] rx,
                                           input logic [1:0] ry);
      logic [1:0] dx;
      logic [1:0] dy;
      dx = d[1:0];
      dy = d[3:2];
      if (dx > rx)      return PORT_EAST;
      else if (dx < rx) return PORT_WEST;
      else if (dy > ry) return PORT_NORTH;
      else if (dy < ry) return PORT_SOUTH;
      else              return PORT_LOCAL;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request scanning upward from ptr, modulo N.
module rr_arbiter #(
   parameter  int N = 5,
   localparam int W = (N > 1) ? $clog2(N) : 1
)(
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W:0] sum;

   // ptr < N and k < N, so a single conditional subtract implements the modulo.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (W+1)'(k);
         if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
         if (!any && req[sum[W-1:0]]) begin
            any              = 1'b1;
            gnt[sum[W-1:0]]  = 1'b1;
            idx              = sum[W-1:0];
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: XY-routes each input, arbitrates round-robin per output and locks
// the output to the winning input until that input drops req.
module switch_allocator
   import noc_pkg::*;
#(
   parameter  int NUM_PORTS    = 5,
   parameter  int ADDRESS_SIZE = 4,
   parameter  int ROUTER_X     = 0,
   parameter  int ROUTER_Y     = 0,
   localparam int SEL_W        = $clog2(NUM_PORTS)
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              req,
   input  logic [NUM_PORTS*ADDRESS_SIZE-1:0] dest,
   output logic [NUM_PORTS-1:0]              grant,
   output logic [NUM_PORTS-1:0]              out_vld,
   output logic [NUM_PORTS*SEL_W-1:0]        out_sel
);

   alloc_state_t [NUM_PORTS-1:0]            state, state_nxt;
   logic [NUM_PORTS-1:0][SEL_W-1:0]         owner, owner_nxt;
   logic [NUM_PORTS-1:0][SEL_W-1:0]         rr_ptr, ptr_nxt;
   logic [NUM_PORTS-1:0][SEL_W-1:0]         sel_q, sel_nxt;
   logic [NUM_PORTS-1:0]                    vld_nxt, grant_nxt;

   logic [NUM_PORTS-1:0][2:0]               route;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     cand;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     arb_gnt;
   logic [NUM_PORTS-1:0][SEL_W-1:0]         arb_idx;
   logic [NUM_PORTS-1:0]                    arb_any;

   assign out_sel = sel_q;

   genvar gi, go;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_route
         assign route[gi] = xy_route(dest[gi*ADDRESS_SIZE +: 4],
                                     2'(ROUTER_X), 2'(ROUTER_Y));
      end

      // A granted input is excluded so an owner never competes for another output.
      for (go = 0; go < NUM_PORTS; go++) begin : g_out
         for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
            assign cand[go][gi] = req[gi] & ~grant[gi] & (route[gi] == 3'(go));
         end

         rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .req (cand[go]),
            .ptr (rr_ptr[go]),
            .gnt (arb_gnt[go]),
            .idx (arb_idx[go]),
            .any (arb_any[go])
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = rr_ptr;
      sel_nxt   = sel_q;
      vld_nxt   = out_vld;
      grant_nxt = grant;
      for (int o = 0; o < NUM_PORTS; o++) begin
         case (state[o])
            FREE: begin
               if (arb_any[o]) begin
                  state_nxt[o] = BUSY;
                  owner_nxt[o] = arb_idx[o];
                  sel_nxt[o]   = arb_idx[o];
                  vld_nxt[o]   = 1'b1;
                  grant_nxt    = grant_nxt | arb_gnt[o];
               end
            end
            BUSY: begin
               // Release edge only frees the output; arbitration resumes next cycle.
               if (!req[owner[o]]) begin
                  state_nxt[o]        = FREE;
                  vld_nxt[o]          = 1'b0;
                  grant_nxt[owner[o]] = 1'b0;
                  ptr_nxt[o]          = (owner[o] == SEL_W'(NUM_PORTS-1)) ? '0
                                                                          : owner[o] + 1'b1;
               end
            end
            default: state_nxt[o] = FREE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= {NUM_PORTS{FREE}};
         owner   <= '0;
         rr_ptr  <= '0;
         sel_q   <= '0;
         out_vld <= '0;
         grant   <= '0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         rr_ptr  <= ptr_nxt;
         sel_q   <= sel_nxt;
         out_vld <= vld_nxt;
         grant   <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator at router (1,1): directed table, corner sequences, random vs model.
module tb_switch_allocator;

   localparam int NP = 5;
   localparam int AS = 4;
   localparam int SW = 3;
   localparam int RX = 1;
   localparam int RY = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     req = '0;
   logic [NP*AS-1:0]  dest = '0;
   logic [NP-1:0]     grant, out_vld;
   logic [NP*SW-1:0]  out_sel;

   int n_chk = 0;
   int n_err = 0;

   switch_allocator #(.NUM_PORTS(NP), .ADDRESS_SIZE(AS), .ROUTER_X(RX), .ROUTER_Y(RY)) dut (
      .clk(clk), .rst(rst), .req(req), .dest(dest),
      .grant(grant), .out_vld(out_vld), .out_sel(out_sel)
   );

   always #5 clk = ~clk;

   // Reference model: owner index per output (-1 = free), pointer and last select per output.
   int         m_owner[NP] = '{default: -1};
   int         m_ptr[NP]   = '{default: 0};
   int         m_sel[NP]   = '{default: 0};
   logic [NP-1:0] m_gnt = '0;
   logic [NP-1:0] m_vld = '0;

   function automatic int route_of(input logic [3:0] d);
      int x, y;
      x = int'(d[1:0]);
      y = int'(d[3:2]);
      if (x > RX) return 2;
      if (x < RX) return 4;
      if (y > RY) return 1;
      if (y < RY) return 3;
      return 0;
   endfunction

   task automatic model_step();
      logic [NP-1:0] g0;
      if (rst) begin
         foreach (m_owner[o]) begin m_owner[o] = -1; m_ptr[o] = 0; m_sel[o] = 0; end
         m_gnt = '0;
         m_vld = '0;
         return;
      end
      g0 = m_gnt;
      for (int o = 0; o < NP; o++) begin
         if (m_owner[o] >= 0) begin
            if (!req[m_owner[o]]) begin
               m_ptr[o] = (m_owner[o] + 1) % NP;
               m_gnt[m_owner[o]] = 1'b0;
               m_vld[o] = 1'b0;
               m_owner[o] = -1;
            end
         end else begin
            for (int k = 0; k < NP; k++) begin
               int i;
               i = (m_ptr[o] + k) % NP;
               if (req[i] && !g0[i] && route_of(dest[i*AS +: AS]) == o) begin
                  m_owner[o] = i;
                  m_sel[o]   = i;
                  m_vld[o]   = 1'b1;
                  m_gnt[i]   = 1'b1;
                  break;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NP*AS-1:0] mkd(input logic [3:0] d0, d1, d2, d3, d4);
      return {d4, d3, d2, d1, d0};
   endfunction

   typedef struct {
      string            nm;
      logic [NP-1:0]    req;
      logic [NP*AS-1:0] dest;
      int               n;
      logic [NP-1:0]    g;
      logic [NP-1:0]    v;
      logic [NP*SW-1:0] s;
   } vec_t;

   function automatic vec_t mkv(input string nm, input logic [NP-1:0] r, input logic [NP*AS-1:0] d,
                                input int n, input logic [NP-1:0] g, v, input logic [NP*SW-1:0] s);
      vec_t t;
      t.nm = nm; t.req = r; t.dest = d; t.n = n; t.g = g; t.v = v; t.s = s;
      return t;
   endfunction

   // dest encodings at (1,1): EAST 0111, WEST 0100, NORTH 1001, SOUTH 0001, LOCAL 0101
   localparam logic [3:0] D_E = 4'b0111, D_W = 4'b0100, D_N = 4'b1001, D_S = 4'b0001, D_L = 4'b0101;

   initial begin
      vec_t vt[$];
      int   ord[3]  = '{1, 3, 4};
      int   eptr[3] = '{2, 4, 0};
      logic [NP*SW-1:0] es;

      vt.push_back(mkv("east_hold",   5'b00001, mkd(D_E, 0, 0, 0, 0),       10, 5'b00001, 5'b00100, 15'h000));
      vt.push_back(mkv("east_rel",    5'b00000, mkd(D_E, 0, 0, 0, 0),        1, 5'b00000, 5'b00000, 15'h000));
      vt.push_back(mkv("par_ns",      5'b00101, mkd(D_N, 0, D_S, 0, 0),      3, 5'b00101, 5'b01010, 15'h400));
      vt.push_back(mkv("par_rel",     5'b00000, mkd(D_N, 0, D_S, 0, 0),      1, 5'b00000, 5'b00000, 15'h400));
      vt.push_back(mkv("lock_east",   5'b00100, mkd(0, 0, D_E, 0, 0),        2, 5'b00100, 5'b00100, 15'h480));
      vt.push_back(mkv("lock_chg",    5'b00100, mkd(0, 0, D_W, 0, 0),        3, 5'b00100, 5'b00100, 15'h480));
      vt.push_back(mkv("lock_rel",    5'b00000, mkd(0, 0, D_W, 0, 0),        1, 5'b00000, 5'b00000, 15'h480));
      vt.push_back(mkv("uturn_local", 5'b00001, mkd(D_L, 0, 0, 0, 0),        2, 5'b00001, 5'b00001, 15'h480));
      vt.push_back(mkv("uturn_rel",   5'b00000, mkd(D_L, 0, 0, 0, 0),        1, 5'b00000, 5'b00000, 15'h480));
      vt.push_back(mkv("south_ptr3",  5'b01010, mkd(0, D_S, 0, D_S, 0),      2, 5'b01000, 5'b01000, 15'h680));
      vt.push_back(mkv("drop_wait",   5'b01000, mkd(0, D_S, 0, D_S, 0),      1, 5'b01000, 5'b01000, 15'h680));
      vt.push_back(mkv("south_rel",   5'b00000, mkd(0, D_S, 0, D_S, 0),      2, 5'b00000, 5'b00000, 15'h680));

      // reset held with all requests high
      rst = 1'b1; req = '1; dest = mkd(D_L, D_L, D_L, D_L, D_L);
      repeat (3) begin
         tick();
         chk("rst_grant", grant, 0);
         chk("rst_vld", out_vld, 0);
      end
      rst = 1'b0;
      chk("post_rst_grant", grant, 0);
      chk("post_rst_vld", out_vld, 0);
      tick();
      chk("first_grant", grant, 5'b00001);
      req = '0; rst = 1'b1;
      tick(); tick();
      rst = 1'b0;

      foreach (vt[r]) begin
         req  = vt[r].req;
         dest = vt[r].dest;
         for (int c = 0; c < vt[r].n; c++) begin
            tick();
            chk({vt[r].nm, "_grant"}, grant, vt[r].g);
            chk({vt[r].nm, "_vld"}, out_vld, vt[r].v);
            chk({vt[r].nm, "_sel"}, out_sel, vt[r].s);
         end
      end

      // contention on WEST: round-robin order and one free cycle between owners
      dest = mkd(D_W, D_W, D_W, D_W, D_W);
      req  = 5'b11010;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("west_grant", grant, 5'b1 << ord[k]);
         chk("west_vld", out_vld, 5'b10000);
         chk("west_sel", out_sel[4*SW +: SW], ord[k]);
         repeat (3) tick();
         chk("west_hold", grant, 5'b1 << ord[k]);
         req[ord[k]] = 1'b0;
         tick();
         chk("west_gap_grant", grant, 0);
         chk("west_gap_vld", out_vld, 0);
         chk("west_ptr", dut.rr_ptr[4], eptr[k]);
      end

      // reset while three outputs are busy
      dest = mkd(D_N, D_E, D_S, 0, 0);
      req  = 5'b00111;
      tick();
      chk("busy3_grant", grant, 5'b00111);
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_grant", grant, 0);
      chk("midrst_vld", out_vld, 0);
      chk("midrst_sel", out_sel, 0);
      rst = 1'b0;
      chk("midrst_after", grant, 0);
      tick();
      chk("regrant_grant", grant, 5'b00111);
      chk("regrant_vld", out_vld, 5'b01110);
      chk("regrant_sel", out_sel, 15'h440);
      req = '0;
      tick(); tick();

      // random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NP; i++) begin
            if (!req[i]) begin
               if ($urandom_range(9) < 3) begin
                  req[i] = 1'b1;
                  dest[i*AS +: AS] = 4'($urandom_range(15));
               end
            end else begin
               int r;
               r = $urandom_range(99);
               if (r < 12)      req[i] = 1'b0;
               else if (r < 20) dest[i*AS +: AS] = 4'($urandom_range(15));
            end
         end
         rst = ($urandom_range(199) == 0);
         tick();
         es = '0;
         for (int o = 0; o < NP; o++) es[o*SW +: SW] = 3'(m_sel[o]);
         chk("rnd_grant", grant, m_gnt);
         chk("rnd_vld", out_vld, m_vld);
         chk("rnd_sel", out_sel, es);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
